// File: rtl/bcd_display_scan.sv
// bcd_display_scan: multiplexed 3-digit BCD display driver with dead-time gaps and per-frame input snapshot
module bcd_display_scan #(
  parameter int DIV  = 50000,
  parameter int DEAD = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] binary,
  input  logic        lz_en,
  output logic [2:0]  an,
  output logic [6:0]  seg,
  output logic        frame_start
);
  typedef enum logic {GAP, SHOW} state_t;
  state_t      state_q, state_d;
  logic [1:0]  slot_q, slot_d;
  logic [15:0] pre_q, pre_d;
  logic [11:0] snap_q, snap_d;
  logic        lz_q, lz_d;
  logic [2:0]  an_d;
  logic [6:0]  seg_d;
  logic        fs_d;
  logic [3:0]  nib;
  logic        blank, last;
  function automatic logic [6:0] dec(input logic [3:0] n);
    case (n)
      4'd0: dec = 7'b1000000;
      4'd1: dec = 7'b1111001;
      4'd2: dec = 7'b0100100;
      4'd3: dec = 7'b0110000;
      4'd4: dec = 7'b0011001;
      4'd5: dec = 7'b0010010;
      4'd6: dec = 7'b0000010;
      4'd7: dec = 7'b1111000;
      4'd8: dec = 7'b0000000;
      4'd9: dec = 7'b0010000;
      default: dec = 7'b0111111;
    endcase
  endfunction
  always_comb begin
    last    = pre_q == 16'(state_q == SHOW ? DIV - 1 : DEAD - 1);
    state_d = last ? (state_q == SHOW ? GAP : SHOW) : state_q;
    pre_d   = last ? 16'd0 : pre_q + 16'd1;
    slot_d  = last && state_q == SHOW ? (slot_q == 2'd2 ? 2'd0 : slot_q + 2'd1) : slot_q;
    snap_d  = last && state_q == GAP && slot_q == 2'd0 ? binary : snap_q;
    lz_d    = last && state_q == GAP && slot_q == 2'd0 ? lz_en : lz_q;
    nib     = slot_q == 2'd2 ? snap_q[11:8] : slot_q == 2'd1 ? snap_q[7:4] : snap_q[3:0];
    // middle zero is leading only when the left digit shows nothing
    blank   = nib == 4'hF || (lz_q && nib == 4'h0 && (slot_q == 2'd2 ||
              (slot_q == 2'd1 && (snap_q[11:8] == 4'h0 || snap_q[11:8] == 4'hF))));
    an_d    = state_q == SHOW ? ~(3'b001 << slot_q) : 3'b111;
    seg_d   = state_q != SHOW || blank ? 7'b1111111 : dec(nib);
    fs_d    = state_q == SHOW && slot_q == 2'd0 && pre_q == 16'd0;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= GAP;
      slot_q      <= 2'd0;
      pre_q       <= 16'd0;
      snap_q      <= 12'hFFF;
      lz_q        <= 1'b0;
      an          <= 3'b111;
      seg         <= 7'b1111111;
      frame_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      pre_q       <= pre_d;
      snap_q      <= snap_d;
      lz_q        <= lz_d;
      an          <= an_d;
      seg         <= seg_d;
      frame_start <= fs_d;
    end
  end
endmodule

// File: tb/tb_bcd_display_scan.sv
// tb_bcd_display_scan: randomized scan-timeline reference model check of bcd_display_scan
module tb_bcd_display_scan;
  localparam int DIV = 4, DEAD = 2, S = DIV + DEAD, P = 3 * S;
  logic        clk, rst, lz_en, frame_start;
  logic [11:0] binary;
  logic [2:0]  an;
  logic [6:0]  seg;
  int          n_chk, n_ok, k;
  logic [11:0] mb;
  logic        ml;
  logic [6:0]  tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
  bcd_display_scan #(.DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .binary(binary), .lz_en(lz_en),
    .an(an), .seg(seg), .frame_start(frame_start)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_ok++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, k);
  endtask
  always @(negedge clk) begin
    logic [2:0] lo;
    lo = ~an;
    check("an_onehot", 32'($countones(lo) <= 1), 1);
  end
  task automatic step(input bit rnd);
    int p, sl, q;
    bit sh, bl;
    logic [3:0] nib, left;
    logic [2:0] ea;
    logic [6:0] es;
    @(posedge clk); #1;
    k++;
    p = (k - 1) % P; sl = p / S; q = p % S; sh = q >= DEAD;
    nib = 4'((mb >> (4 * sl)) & 12'hF);
    left = mb[11:8];
    bl = nib == 4'hF || (ml && nib == 0 && (sl == 2 || (sl == 1 && (left == 0 || left == 4'hF))));
    es = !sh || bl ? 7'h7F : nib > 9 ? 7'h3F : tbl[nib];
    ea = sh ? 3'(~(3'b001 << sl)) : 3'b111;
    check("an", an, ea);
    check("seg", seg, es);
    check("frame_start", frame_start, sh && sl == 0 && q == DEAD);
    if (k % P == DEAD) begin mb = binary; ml = lz_en; end
    if (rnd && $urandom_range(0, 7) == 0) begin
      for (int i = 0; i < 3; i++) binary[4*i +: 4] = 4'($urandom_range(0, 15));
      lz_en = 1'($urandom_range(0, 1));
    end
  endtask
  task automatic run_until(input int pos);
    for (int i = 0; i < P && (k - 1) % P != pos; i++) step(0);
  endtask
  task automatic apply(input logic [11:0] b, input logic l);
    binary = b; lz_en = l;
    repeat (2 * P) step(0);
  endtask
  initial begin
    n_chk = 0; n_ok = 0; k = 0; mb = 12'hFFF; ml = 0;
    rst = 1; binary = 12'h123; lz_en = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_an", an, 3'b111);
    check("rst_seg", seg, 7'h7F);
    check("rst_fs", frame_start, 0);
    rst = 0;
    repeat (3 * P) step(0);
    apply(12'h007, 1);
    apply(12'h007, 0);
    apply(12'hFF5, 0);
    apply(12'hA0C, 0);
    apply(12'h0F0, 1);
    apply(12'hF05, 1);
    apply(12'h111, 0);
    run_until(S + DEAD);
    binary = 12'h999;
    repeat (2 * P) step(0);
    run_until(S + DEAD + 1);
    #1 rst = 1;
    #1;
    check("async_an", an, 3'b111);
    check("async_seg", seg, 7'h7F);
    check("async_fs", frame_start, 0);
    rst = 0; k = 0; mb = 12'hFFF; ml = 0;
    repeat (2 * P) step(0);
    repeat (600) step(1);
    $display("%0d/%0d checks passed", n_ok, n_chk);
    $finish;
  end
endmodule
